// File: rtl/oai221_cell_bist.sv
// ---------------------------------------------------------------------------
// oai221_cell_bist
//
// Built-in self-test engine for a single 5-input complex-gate cell instance
// (OAI221 or AOI221). The engine drives the cell's input pins with all 32
// input vectors. It waits a programmable settle time for each vector, then
// samples the cell's ZN output. Each sample is compared with the expected
// logic function. At the end of a run the engine reports pass/fail, a
// saturating mismatch count and the first failing vector.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before ZN is sampled (>= 1)
//   ERR_W          width of ERR_CNT; the counter saturates at all-ones
//   FUNC           0 = OAI221  ZN = ~((A1|A2)&(B1|B2)&C)
//                  1 = AOI221  ZN = ~((A1&A2)|(B1&B2)|C)
//
// Ports
//   CLK          in   rising-edge clock
//   RST          in   synchronous active-high reset, has priority over START
//   START        in   one-cycle run request, honoured only when idle or done
//   ZN           in   output of the cell under test
//   A1,A2,B1,B2  out  registered drive pins to the cell under test
//   C            out  registered drive pin to the cell under test
//   BUSY         out  high while a run is in progress
//   DONE         out  high after a run completes, held until START or RST
//   PASS         out  valid while DONE=1; 1 = no mismatches in the run
//   ERR_CNT      out  saturating mismatch count for the current/last run
//   FAIL_VALID   out  at least one mismatch captured in this run
//   FIRST_FAIL   out  first failing vector, packed as {C,B2,B1,A2,A1}
//   VDD,VSS      io   supply pins of the cell; no functional effect
// ---------------------------------------------------------------------------
module oai221_cell_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6,
  parameter int FUNC          = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [4:0]       FIRST_FAIL,
  inout  wire              VDD,
  inout  wire              VSS
);

  // The settle counter runs from 0 to SETTLE_CYCLES-1.
  // It is at least one bit wide so that SETTLE_CYCLES=1 still elaborates.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [4:0]       LAST_VEC    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [4:0]       vec;
  logic [4:0]       drive;
  logic [CNT_W-1:0] settle_cnt;
  logic             exp_zn;
  logic             mismatch;

  // The supply pins only exist so the engine can be dropped onto a
  // powered cell netlist. Naming the signal *_unused marks it as
  // deliberately unconsumed.
  wire supply_unused = VDD ^ VSS;

  // The drive pins are a registered copy of the vector, packed as
  // {C,B2,B1,A2,A1}. They therefore only change on the same clock edge
  // as the vector register.
  assign {C, B2, B1, A2, A1} = drive;

  // Expected cell response for the vector currently being applied.
  // Bit order of vec: [0]=A1 [1]=A2 [2]=B1 [3]=B2 [4]=C.
  always_comb begin
    exp_zn = 1'b0;
    if (FUNC == 1) begin
      exp_zn = ~((vec[0] & vec[1]) | (vec[2] & vec[3]) | vec[4]);
    end else begin
      exp_zn = ~((vec[0] | vec[1]) & (vec[2] | vec[3]) & vec[4]);
    end
  end

  // A case-inequality is used so that an X or Z on ZN is reported as a
  // mismatch in simulation. A floating or contended cell output must not
  // be reported as passing. Synthesis treats this as a plain inequality.
  always_comb begin
    mismatch = (ZN !== exp_zn);
  end

  // Sequencer and result registers. A run cycles through SETTLE (hold the
  // vector for SETTLE_CYCLES cycles) and SAMPLE (one compare cycle) for
  // each of the 32 vectors. The run then parks in DONE with the vector and
  // drive pins left at 31. START is deliberately ignored while a run is in
  // progress, so a stray pulse cannot restart a half-finished test.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      vec        <= '0;
      drive      <= '0;
      settle_cnt <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VALID <= 1'b0;
      FIRST_FAIL <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state      <= ST_SETTLE;
            vec        <= '0;
            drive      <= '0;
            settle_cnt <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FIRST_FAIL <= '0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          // Only the first mismatch of a run is recorded as FIRST_FAIL.
          // The error count saturates at ERR_MAX instead of wrapping.
          if (mismatch) begin
            if (ERR_CNT != ERR_MAX) begin
              ERR_CNT <= ERR_CNT + 1'b1;
            end
            if (!FAIL_VALID) begin
              FIRST_FAIL <= vec;
              FAIL_VALID <= 1'b1;
            end
          end

          if (vec != LAST_VEC) begin
            vec        <= vec + 5'd1;
            drive      <= vec + 5'd1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else begin
            // FAIL_VALID does not yet include this final sample, so the
            // mismatch for vector 31 is folded into PASS here.
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= ~(FAIL_VALID | mismatch);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
